// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and classification helpers for the FP datapath units.
package fp32_pkg;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [22:0] f;
  } fp32_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;

  function automatic fp_class_e fp_class(input fp32_t v);
    if (v.e == EXP_MAX) return (v.f != 23'd0) ? FP_NAN : FP_INF;
    if (v.e == 8'd0)    return (v.f != 23'd0) ? FP_SUB : FP_ZERO;
    return FP_NORM;
  endfunction

  // Subnormals share the scale of exponent 1, just without the hidden bit.
  function automatic logic [7:0] eff_exp(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : e;
  endfunction

endpackage

// File: rtl/fp32_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined binary32 adder/subtractor.
interface fp32_addsub_pipe_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_x;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;
  logic             out_inv;
  logic             out_inx;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_tag, out_ovf, out_inv, out_inx
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_tag, out_ovf, out_inv, out_inx
  );
endinterface

// File: rtl/fp32_norm_round.sv
// Combinational normalise, round-to-nearest-even and pack of a 28-bit significand sum
// ({carry, hidden, 23 frac, G, R, S}) into binary32 with overflow/inexact flags.
module fp32_norm_round
  import fp32_pkg::*;
(
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [27:0] sum,
  output logic [31:0] x,
  output logic        ovf,
  output logic        inx
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic rne_up(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  function automatic logic [31:0] sat_pack(input logic s, input logic [9:0] e, input logic hid,
                                           input logic [22:0] frac);
    if (e >= 10'd255) return {s, EXP_MAX, 23'd0};
    return {s, hid ? e[7:0] : 8'd0, frac};
  endfunction

  logic [4:0]  lz;
  logic [7:0]  room;
  logic [4:0]  shl;
  logic [26:0] m;
  logic [9:0]  e_n;
  logic [9:0]  e_r;
  logic [24:0] mr;
  logic        hid;
  logic [22:0] frac;

  always_comb begin
    lz   = lzc27(sum[26:0]);
    room = exp - 8'd1;
    // Left shift stops at exponent 1 so tiny results fall out as subnormals.
    shl  = (room < {3'd0, lz}) ? room[4:0] : lz;
    if (sum[27]) begin
      m   = {sum[27:2], sum[1] | sum[0]};
      e_n = {2'd0, exp} + 10'd1;
    end else begin
      m   = sum[26:0] << shl;
      e_n = {2'd0, exp} - {5'd0, shl};
    end
    mr = {1'b0, m[26:3]} + {24'd0, rne_up(m[3], m[2], m[1], m[0])};
    if (mr[24]) begin
      hid  = 1'b1;
      frac = mr[23:1];
      e_r  = e_n + 10'd1;
    end else begin
      hid  = mr[23];
      frac = mr[22:0];
      e_r  = e_n;
    end
    ovf = (e_r >= 10'd255);
    inx = (|m[2:0]) | ovf;
    x   = sat_pack(sign, e_r, hid, frac);
  end

endmodule

// File: rtl/fp32_addsub_pipe.sv
// Three-stage binary32 add/subtract (align / add / normalise+round) with a global
// stall: every stage holds while the result register is valid and not accepted.
module fp32_addsub_pipe
  import fp32_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int STAGES = 3
) (
  input logic               clk,
  input logic               rst_n,
  fp32_addsub_pipe_if.slave bus
);

  if (STAGES != 3) begin : g_stages_check
    $error("fp32_addsub_pipe: STAGES must be 3");
  end

  function automatic logic [26:0] align_sticky(input logic [23:0] m, input logic [4:0] sh);
    logic [49:0] ext;
    ext = {m, 26'd0} >> sh;
    return {ext[49:24], |ext[23:0]};
  endfunction

  logic stall;
  logic vld_p1, vld_p2, vld_p3;

  assign stall        = vld_p3 && !bus.out_ready;
  assign bus.in_ready = !stall;

  fp32_t       a, b;
  fp_class_e   ca, cb;
  logic        a_big, s_big;
  logic [7:0]  e_big, e_sml, e_diff;
  logic [23:0] m_big, m_sml;
  logic [26:0] aligned;
  logic        spec;
  logic [31:0] spec_x;
  logic        spec_inv;

  always_comb begin
    a      = bus.in_a;
    b      = bus.in_b;
    b.s    = bus.in_b[31] ^ bus.in_sub;
    ca     = fp_class(a);
    cb     = fp_class(b);
    a_big  = (a[30:0] >= b[30:0]);
    s_big  = a_big ? a.s : b.s;
    e_big  = eff_exp(a_big ? a.e : b.e);
    e_sml  = eff_exp(a_big ? b.e : a.e);
    m_big  = a_big ? {a.e != 8'd0, a.f} : {b.e != 8'd0, b.f};
    m_sml  = a_big ? {b.e != 8'd0, b.f} : {a.e != 8'd0, a.f};
    e_diff = e_big - e_sml;
    aligned = align_sticky(m_sml, (e_diff > 8'd26) ? 5'd26 : e_diff[4:0]);
    spec     = 1'b1;
    spec_x   = FP32_QNAN;
    spec_inv = 1'b1;
    if (ca == FP_NAN || cb == FP_NAN) begin
      spec_inv = 1'b1;
    end else if (ca == FP_INF && cb == FP_INF && a.s != b.s) begin
      spec_inv = 1'b1;
    end else if (ca == FP_INF) begin
      spec_x   = a;
      spec_inv = 1'b0;
    end else if (cb == FP_INF) begin
      spec_x   = b;
      spec_inv = 1'b0;
    end else begin
      spec     = 1'b0;
      spec_inv = 1'b0;
    end
  end

  // ---- stage 1: aligned operands ----
  logic [TAG_W-1:0] tag_p1;
  logic             s_p1, sub_p1, spec_p1, spec_inv_p1;
  logic [7:0]       e_p1;
  logic [23:0]      mb_p1;
  logic [26:0]      ms_p1;
  logic [31:0]      spec_x_p1;

  always_ff @(posedge clk) begin
    if (!stall) begin
      tag_p1      <= bus.in_tag;
      s_p1        <= s_big;
      sub_p1      <= a.s ^ b.s;
      e_p1        <= e_big;
      mb_p1       <= m_big;
      ms_p1       <= aligned;
      spec_p1     <= spec;
      spec_x_p1   <= spec_x;
      spec_inv_p1 <= spec_inv;
    end
  end

  // ---- stage 2: significand sum ----
  logic [TAG_W-1:0] tag_p2;
  logic             s_p2, sub_p2, spec_p2, spec_inv_p2;
  logic [7:0]       e_p2;
  logic [27:0]      sum_p2;
  logic [31:0]      spec_x_p2;

  always_ff @(posedge clk) begin
    if (!stall) begin
      tag_p2      <= tag_p1;
      s_p2        <= s_p1;
      sub_p2      <= sub_p1;
      e_p2        <= e_p1;
      sum_p2      <= sub_p1 ? ({1'b0, mb_p1, 3'd0} - {1'b0, ms_p1})
                            : ({1'b0, mb_p1, 3'd0} + {1'b0, ms_p1});
      spec_p2     <= spec_p1;
      spec_x_p2   <= spec_x_p1;
      spec_inv_p2 <= spec_inv_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= bus.in_valid;
      vld_p2 <= vld_p1;
    end
  end

  logic        nr_sign, nr_ovf, nr_inx;
  logic [31:0] nr_x;

  // Exact cancellation always returns +0; only a true add of two zeros keeps their sign.
  assign nr_sign = (sum_p2 == 28'd0 && sub_p2) ? 1'b0 : s_p2;

  fp32_norm_round u_norm_round (
    .sign (nr_sign),
    .exp  (e_p2),
    .sum  (sum_p2),
    .x    (nr_x),
    .ovf  (nr_ovf),
    .inx  (nr_inx)
  );

  // ---- stage 3: packed result ----
  logic [31:0]      x_p3;
  logic [TAG_W-1:0] tag_p3;
  logic             ovf_p3, inv_p3, inx_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p3 <= 1'b0;
      x_p3   <= 32'd0;
      tag_p3 <= '0;
      ovf_p3 <= 1'b0;
      inv_p3 <= 1'b0;
      inx_p3 <= 1'b0;
    end else if (!stall) begin
      vld_p3 <= vld_p2;
      x_p3   <= spec_p2 ? spec_x_p2 : nr_x;
      tag_p3 <= tag_p2;
      ovf_p3 <= !spec_p2 && nr_ovf;
      inv_p3 <= spec_p2 && spec_inv_p2;
      inx_p3 <= !spec_p2 && nr_inx;
    end
  end

  assign bus.out_valid = vld_p3;
  assign bus.out_x     = x_p3;
  assign bus.out_tag   = tag_p3;
  assign bus.out_ovf   = ovf_p3;
  assign bus.out_inv   = inv_p3;
  assign bus.out_inx   = inx_p3;

endmodule

// File: tb/tb_fp32_addsub_pipe.sv
// Bench for fp32_addsub_pipe: directed vectors, stall/ordering, reset flush and random
// traffic scored against an exact-integer binary32 reference.
module tb_fp32_addsub_pipe;
  import fp32_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp32_addsub_pipe_if #(.TAG_W(4)) bus ();

  fp32_addsub_pipe #(.TAG_W(4), .STAGES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [34:0] res;  // {ovf, inv, inx, x}
    logic [3:0]  tag;
    int          t;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic lat_chk = 1'b0;

  logic [31:0] specials [9] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h807FFFFF,
                                32'h7F7FFFFF};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-149, are summed exactly,
  // then rounded to nearest-even into binary32.
  function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
    logic        sa, sb, s, up;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [279:0] ma, mb, m, rem, half;
    logic [24:0] mant;
    int          p, sh, e;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31] ^ sub; eb = b[30:23]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 23'd0) || (eb == 8'hFF && fb != 23'd0)) return {3'b010, FP32_QNAN};
    if (ea == 8'hFF && eb == 8'hFF)
      return (sa != sb) ? {3'b010, FP32_QNAN} : {3'b000, sa, 8'hFF, 23'd0};
    if (ea == 8'hFF) return {3'b000, sa, 8'hFF, 23'd0};
    if (eb == 8'hFF) return {3'b000, sb, 8'hFF, 23'd0};
    ma = (ea == 8'd0) ? 280'(fa) : (280'({1'b1, fa}) << (int'(ea) - 1));
    mb = (eb == 8'd0) ? 280'(fb) : (280'({1'b1, fb}) << (int'(eb) - 1));
    if (sa == sb) begin m = ma + mb; s = sa; end
    else if (ma >= mb) begin m = ma - mb; s = sa; end
    else begin m = mb - ma; s = sb; end
    if (m == 280'd0) return {3'b000, sa & sb, 31'd0};
    if (m < 280'h1000000) return {3'b000, s, m[30:0]};
    p = 0;
    for (int i = 279; i >= 0; i--) begin
      if (m[i]) begin p = i; break; end
    end
    sh   = p - 23;
    mant = 25'(m >> sh);
    rem  = m & ((280'd1 << sh) - 280'd1);
    half = 280'd1 << (sh - 1);
    up   = (rem > half) || (rem == half && mant[0]);
    mant = mant + 25'(up);
    e    = sh + 1;
    if (mant[24]) begin mant = mant >> 1; e++; end
    if (e >= 255) return {3'b101, s, 8'hFF, 23'd0};
    return {2'b00, rem != 280'd0, s, 8'(e), mant[22:0]};
  endfunction

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic [3:0] tag, input logic rdy,
                      input logic use_ex, input logic [34:0] ex, output logic took);
    exp_t e;
    @(negedge clk);
    cyc++;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sub    = sub;
    bus.in_tag    = tag;
    bus.out_ready = rdy;
    #1;
    took = v && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("x", 64'(bus.out_x), 64'(e.res[31:0]));
        chk("tag", 64'(bus.out_tag), 64'(e.tag));
        chk("flags_ovf_inv_inx", 64'({bus.out_ovf, bus.out_inv, bus.out_inx}), 64'(e.res[34:32]));
        if (lat_chk) chk("latency", 64'(cyc - e.t), 64'd3);
      end
    end
    if (took) begin
      e.res = use_ex ? ex : ref_add(a, b, sub);
      e.tag = tag;
      e.t   = cyc;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    logic took;
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 35'd0, took);
  endtask

  task automatic rnd_pair(output logic [31:0] a, output logic [31:0] b);
    logic [7:0] e;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 4))
      0: ;
      1: begin
        e = a[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
        b = {1'($urandom), e, 23'($urandom)};
      end
      2: b = a ^ 32'($urandom_range(0, 255)) ^ {1'($urandom), 31'd0};
      3: a = specials[$urandom_range(0, 8)];
      default: begin
        a = {1'($urandom), 7'd0, 1'($urandom), 23'($urandom)};
        b = {1'($urandom), 7'd0, 1'($urandom), 23'($urandom)};
      end
    endcase
  endtask

  logic [31:0] d_a   [7] = '{32'h3FC00000, 32'h3F800000, 32'h80000000, 32'h7F7FFFFF,
                             32'h7F800000, 32'h007FFFFF, 32'h00800000};
  logic [31:0] d_b   [7] = '{32'h40200000, 32'h3F800000, 32'h80000000, 32'h7F7FFFFF,
                             32'hFF800000, 32'h00800000, 32'h80800001};
  logic        d_sub [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [34:0] d_ex  [7] = '{{3'b000, 32'h40800000}, {3'b000, 32'h00000000},
                             {3'b000, 32'h80000000}, {3'b101, 32'h7F800000},
                             {3'b010, 32'h7FC00000}, {3'b000, 32'h00FFFFFF},
                             {3'b000, 32'h80000001}};

  initial begin
    logic        took;
    logic [31:0] ra, rb;
    logic [31:0] opa [8];
    logic [31:0] opb [8];
    int          i, s, ntx, guard;

    bus.in_valid = 1'b0; bus.in_a = 32'd0; bus.in_b = 32'd0;
    bus.in_sub = 1'b0; bus.in_tag = 4'd0; bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("in_reset_out_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_x", 64'(bus.out_x), 64'd0);
    chk("reset_out_tag", 64'(bus.out_tag), 64'd0);
    chk("reset_flags", 64'({bus.out_ovf, bus.out_inv, bus.out_inx}), 64'd0);

    // Directed vectors, back to back, with exact latency checking.
    lat_chk = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, d_a[k], d_b[k], d_sub[k], 4'(k), 1'b1, 1'b1, d_ex[k], took);
      chk("directed_accept", 64'(took), 64'd1);
    end
    idle(6);
    chk("directed_drain", 64'(q.size()), 64'd0);
    lat_chk = 1'b0;

    // Eight-op stream with the consumer stalled on steps 4..9.
    for (int k = 0; k < 8; k++) begin
      rnd_pair(ra, rb);
      opa[k] = ra;
      opb[k] = rb;
    end
    i = 0;
    s = 0;
    while ((i < 8 || q.size() != 0) && s < 60) begin
      step(i < 8, opa[i < 8 ? i : 0], opb[i < 8 ? i : 0], 1'b0, 4'(i), !(s >= 4 && s <= 9),
           1'b0, 35'd0, took);
      if (took) i++;
      if (s >= 4 && s <= 9) begin
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_out_tag", 64'(bus.out_tag), 64'd1);
        if (q.size() != 0) chk("stall_out_x", 64'(bus.out_x), 64'(q[0].res[31:0]));
      end
      s++;
    end
    chk("stream_all_accepted", 64'(i), 64'd8);
    chk("stream_drain", 64'(q.size()), 64'd0);

    // Reset with three operations in flight.
    for (int k = 0; k < 3; k++) begin
      rnd_pair(ra, rb);
      step(1'b1, ra, rb, 1'b0, 4'(k), 1'b1, 1'b0, 35'd0, took);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("inflight_out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_out_x", 64'(bus.out_x), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 35'd0, took);
      chk("no_stale_out_valid", 64'(bus.out_valid), 64'd0);
    end

    // Random traffic with random bubbles and back-pressure.
    ntx = 0;
    guard = 0;
    rnd_pair(ra, rb);
    while (ntx < 20000 && guard < 60000) begin
      step($urandom_range(0, 9) < 8, ra, rb, 1'($urandom), 4'($urandom),
           $urandom_range(0, 9) < 8, 1'b0, 35'd0, took);
      if (took) begin
        ntx++;
        rnd_pair(ra, rb);
      end
      guard++;
    end
    chk("random_all_issued", 64'(ntx), 64'd20000);
    idle(20);
    chk("random_drain", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
